jt89_psg_gen: RTL and testbench

Parametrised SN76489-family PSG core: three square-wave tone channels plus one noise channel, with configurable tone-counter width, prescaler, noise LFSR width and taps, and optional Game Gear-style stereo panning. It adds a real READY handshake that stalls the bus after every accepted write. It produces two unsigned mixed outputs (left/right) and sits directly behind the CPU bus in a sound subsystem, ahead of any DC-removal or resampling stage.

---
 rtl/jt89_psg_gen.sv | 198 +++++++++++++++++++
 tb/tb_jt89_psg_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/jt89_psg_gen.sv
// jt89_psg_gen: SN76489-family programmable sound generator core.
//   Three square-wave tone channels plus one LFSR noise channel, 2 dB-step
//   attenuation, optional Game Gear-style stereo panning and a READY
//   handshake that stalls the bus for WAIT clk_en pulses after each write.
// Ports:
//   clk      system clock, all state on the rising edge
//   rst_n    asynchronous active-low reset
//   clk_en   chip clock enable (prescaler, channels, READY counter)
//   wr_n     main register write strobe, active low, edge-detected
//   st_wr_n  stereo register write strobe, active low, edge-detected
//   din      write data for both ports
//   sound_l  unsigned left mix (registered)
//   sound_r  unsigned right mix (registered)
//   ready    high when the next write will be accepted
module jt89_psg_gen #(
  parameter int unsigned     TW     = 10,
  parameter int unsigned     DIV    = 16,
  parameter int unsigned     NW     = 16,
  parameter logic [NW-1:0]   TAPS   = 16'h0009,
  parameter bit              STEREO = 1'b1,
  parameter int unsigned     WAIT   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       wr_n,
  input  logic       st_wr_n,
  input  logic [7:0] din,
  output logic [9:0] sound_l,
  output logic [9:0] sound_r,
  output logic       ready
);

  localparam int unsigned   PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned   WBW  = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [NW-1:0] SEED = {1'b1, {(NW-1){1'b0}}};

  logic          wr_q, st_q, wr_acc, st_acc, noise_wr;
  logic [2:0]    reg_sel;
  logic [PW-1:0] pre;
  logic          tick;
  logic [TW-1:0] period  [3];
  logic [TW-1:0] cnt     [3];
  logic [TW-1:0] cnt_nxt [3];
  logic [2:0]    tone, tone_nxt;
  logic [3:0]    vol [4];
  logic [2:0]    regn, ctrl3;
  logic [7:0]    stereo;
  logic [NW-1:0] lfsr, lfsr_shift;
  logic [5:0]    ncnt, ncnt_lim;
  logic          nclk, nclk_nxt, src_cur, src_nxt, shift;
  logic [3:0]    ch_on, en_l, en_r;
  logic [9:0]    mix_l, mix_r;

  function automatic logic [7:0] amp(input logic [3:0] v);
    case (v)
      4'd0:    amp = 8'd255;
      4'd1:    amp = 8'd203;
      4'd2:    amp = 8'd161;
      4'd3:    amp = 8'd128;
      4'd4:    amp = 8'd102;
      4'd5:    amp = 8'd81;
      4'd6:    amp = 8'd64;
      4'd7:    amp = 8'd51;
      4'd8:    amp = 8'd40;
      4'd9:    amp = 8'd32;
      4'd10:   amp = 8'd26;
      4'd11:   amp = 8'd20;
      4'd12:   amp = 8'd16;
      4'd13:   amp = 8'd13;
      4'd14:   amp = 8'd10;
      default: amp = 8'd0;
    endcase
  endfunction

  assign wr_acc   = ready & wr_q & ~wr_n;
  assign st_acc   = ready & st_q & ~st_wr_n;
  assign reg_sel  = din[7] ? din[6:4] : regn;
  assign noise_wr = wr_acc & (reg_sel == 3'b110);
  assign tick     = clk_en & (pre == PW'(DIV - 1));

  // Periods 0/1 hold the output high; the counter parks at 0 so a newly
  // written period starts on the very next tick instead of after a wrap.
  always_comb begin
    tone_nxt = tone;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_nxt[i] = cnt[i];
      if (period[i] <= TW'(1)) begin
        tone_nxt[i] = 1'b1;
        cnt_nxt[i]  = '0;
      end else if (cnt[i] == '0) begin
        cnt_nxt[i]  = period[i] - TW'(1);
        tone_nxt[i] = ~tone[i];
      end else begin
        cnt_nxt[i] = cnt[i] - TW'(1);
      end
    end
  end

  // Shift-clock edge is judged on next-vs-current value so the LFSR moves on
  // the same tick that raises its clock, whichever source is selected.
  always_comb begin
    case (ctrl3[1:0])
      2'b00:   ncnt_lim = 6'd15;
      2'b01:   ncnt_lim = 6'd31;
      default: ncnt_lim = 6'd63;
    endcase
    nclk_nxt   = (ncnt >= ncnt_lim) ? ~nclk : nclk;
    src_cur    = (ctrl3[1:0] == 2'b11) ? tone[2]     : nclk;
    src_nxt    = (ctrl3[1:0] == 2'b11) ? tone_nxt[2] : nclk_nxt;
    shift      = tick & src_nxt & ~src_cur;
    lfsr_shift = {(ctrl3[2] ? ^(lfsr & TAPS) : lfsr[0]), lfsr[NW-1:1]};
    if (lfsr_shift == '0) lfsr_shift = SEED;
  end

  always_comb begin
    ch_on = {lfsr[0], tone};
    en_l  = STEREO ? stereo[7:4] : 4'hF;
    en_r  = STEREO ? stereo[3:0] : 4'hF;
    mix_l = '0;
    mix_r = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ch_on[i] && en_l[i]) mix_l = mix_l + 10'(amp(vol[i]));
      if (ch_on[i] && en_r[i]) mix_r = mix_r + 10'(amp(vol[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b1;
      st_q    <= 1'b1;
      pre     <= '0;
      tone    <= '0;
      regn    <= '0;
      ctrl3   <= 3'b100;
      stereo  <= '1;
      lfsr    <= SEED;
      ncnt    <= '0;
      nclk    <= 1'b0;
      sound_l <= '0;
      sound_r <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        period[i] <= '0;
        cnt[i]    <= '0;
      end
      for (int unsigned i = 0; i < 4; i++) vol[i] <= '1;
    end else begin
      wr_q <= wr_n;
      st_q <= st_wr_n;
      if (clk_en) pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        for (int unsigned i = 0; i < 3; i++) cnt[i] <= cnt_nxt[i];
        tone <= tone_nxt;
        ncnt <= (ncnt >= ncnt_lim) ? '0 : ncnt + 6'd1;
        nclk <= nclk_nxt;
      end
      if (wr_acc) begin
        if (din[7]) regn <= din[6:4];
        for (int unsigned i = 0; i < 3; i++) begin
          if (!reg_sel[0] && reg_sel[2:1] == 2'(i)) begin
            if (din[7]) period[i][3:0]    <= din[3:0];
            else        period[i][TW-1:4] <= din[TW-5:0];
          end
        end
        for (int unsigned i = 0; i < 4; i++) begin
          if (reg_sel[0] && reg_sel[2:1] == 2'(i)) vol[i] <= din[3:0];
        end
        if (noise_wr) ctrl3 <= din[2:0];
      end
      if (noise_wr)   lfsr <= SEED;
      else if (shift) lfsr <= lfsr_shift;
      if (STEREO && st_acc) stereo <= din;
      sound_l <= mix_l;
      sound_r <= mix_r;
    end
  end

  generate
    if (WAIT == 0) begin : g_nowait
      assign ready = 1'b1;
    end else begin : g_wait
      logic [WBW-1:0] wcnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ready <= 1'b1;
          wcnt  <= '0;
        end else if (wr_acc || st_acc) begin
          ready <= 1'b0;
          wcnt  <= '0;
        end else if (!ready && clk_en) begin
          if (wcnt == WBW'(WAIT - 1)) ready <= 1'b1;
          else                        wcnt  <= wcnt + WBW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_jt89_psg_gen.sv
`timescale 1ns/1ps
module tb_jt89_psg_gen;

  logic       clk = 1'b0, rst_n = 1'b0, clk_en = 1'b1, wr_n = 1'b1, st_wr_n = 1'b1;
  logic [7:0] din = '0;
  logic [9:0] sl, sr, ml, mr;
  logic       rdy, mrdy;

  jt89_psg_gen u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_n(wr_n), .st_wr_n(st_wr_n),
    .din(din), .sound_l(sl), .sound_r(sr), .ready(rdy)
  );

  jt89_psg_gen #(.STEREO(1'b0)) u_mono (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .wr_n(wr_n), .st_wr_n(st_wr_n),
    .din(din), .sound_l(ml), .sound_r(mr), .ready(mrdy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0, n_bad = 0;

  typedef struct {
    int unsigned at;
    int unsigned sig;
    logic [9:0]  val;
    string       name;
  } exp_t;
  exp_t sb[$];

  function automatic logic [9:0] probe(input int unsigned sig);
    case (sig)
      0:       return sl;
      1:       return sr;
      2:       return {9'd0, rdy};
      3:       return ml;
      4:       return mr;
      default: return {9'd0, mrdy};
    endcase
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, want);
    end
  endtask

  task automatic expect_at(input int unsigned at, input int unsigned sig,
                           input logic [9:0] val, input string name);
    sb.push_back('{at, sig, val, name});
  endtask

  task automatic expect_mix(input int unsigned at, input logic [9:0] l, input logic [9:0] r,
                            input logic [9:0] m, input string name);
    expect_at(at, 0, l, {name, "_l"});
    expect_at(at, 1, r, {name, "_r"});
    expect_at(at, 3, m, {name, "_mono_l"});
    expect_at(at, 4, m, {name, "_mono_r"});
  endtask

  // Monitor: compares every scoreboard entry whose cycle has arrived.
  always @(negedge clk) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].at <= cyc) begin
        check(sb[i].name, probe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic strobe(input logic [7:0] d, input bit st, output int unsigned e);
    @(negedge clk);
    din = d;
    if (st) st_wr_n = 1'b0; else wr_n = 1'b0;
    @(negedge clk);
    wr_n = 1'b1; st_wr_n = 1'b1;
    e = cyc;
  endtask

  task automatic wr(input logic [7:0] d, input bit st);
    int unsigned e;
    strobe(d, st, e);
    repeat (34) @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_val(input logic [9:0] v, input bit eq, input int unsigned bound,
                          input string name, output int unsigned c);
    for (int unsigned k = 0; k < bound; k++) begin
      @(negedge clk);
      if ((sl == v) == eq) begin
        c = cyc;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL %s: sound_l wait timed out after %0d cycles, want %s %0d",
             name, bound, eq ? "==" : "!=", v);
    c = cyc;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e1, e2, c, c0, c1, c2, ew, ep, es;

    // Reset held with strobes toggling: outputs stay at reset values.
    for (int unsigned k = 0; k < 8; k++) begin
      @(negedge clk);
      wr_n = k[0]; st_wr_n = ~k[0]; din = 8'h90;
      expect_at(cyc + 1, 0, 10'd0, "rst_sound_l");
      expect_at(cyc + 1, 1, 10'd0, "rst_sound_r");
      expect_at(cyc + 1, 2, 10'd1, "rst_ready");
    end
    @(negedge clk); wr_n = 1'b1; st_wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    expect_mix(cyc + 2, 10'd0, 10'd0, 10'd0, "post_rst");
    expect_at(cyc + 2, 2, 10'd1, "post_rst_ready");
    repeat (4) @(negedge clk);

    // READY: low for exactly WAIT pulses; a write during the wait is dropped.
    strobe(8'h9F, 1'b0, e1);
    expect_at(e1 + 1, 2, 10'd0, "ready_low_start");
    expect_at(e1 + 11, 2, 10'd0, "ready_low_mid");
    expect_at(e1 + 31, 2, 10'd0, "ready_low_last");
    expect_at(e1 + 32, 2, 10'd1, "ready_high");
    expect_at(e1 + 32, 5, 10'd1, "mono_ready_high");
    wait_cyc(e1 + 9);
    strobe(8'hB0, 1'b0, e2);
    expect_at(e1 + 50, 2, 10'd1, "ready_not_restarted");
    expect_mix(e1 + 60, 10'd0, 10'd0, 10'd0, "dropped_write");
    wait_cyc(e1 + 65);

    // Tone0 period 5, vol 0: 255/0 square with 80-clock half period.
    wr(8'h85, 1'b0); wr(8'h00, 1'b0); wr(8'h90, 1'b0);
    wait_val(10'd0, 1'b1, 200, "tone0_low", c);
    wait_val(10'd255, 1'b1, 200, "tone0_rise", c0);
    expect_mix(c0 + 79,  10'd255, 10'd255, 10'd255, "tone0_hi_end");
    expect_mix(c0 + 80,  10'd0,   10'd0,   10'd0,   "tone0_fall");
    expect_mix(c0 + 159, 10'd0,   10'd0,   10'd0,   "tone0_lo_end");
    expect_mix(c0 + 160, 10'd255, 10'd255, 10'd255, "tone0_rise2");
    wait_cyc(c0 + 165);

    // White noise from seed 16'h8000, taps 0x0009: lfsr[0]=1 after shifts
    // 15, 28 and 31; one shift every 32 ticks = 512 clocks.
    wr(8'h9F, 1'b0);
    strobe(8'hE4, 1'b0, ew);
    repeat (34) @(negedge clk);
    wr(8'hF0, 1'b0);
    wait_val(10'd255, 1'b1, 16 * 512, "white_first_one", c0);
    check("white_first_one_time", 10'((c0 - ew > 14 * 512) && (c0 - ew <= 15 * 512 + 20)), 10'd1);
    expect_mix(c0 + 511,  10'd255, 10'd255, 10'd255, "white_s15");
    expect_mix(c0 + 512,  10'd0,   10'd0,   10'd0,   "white_s16");
    expect_mix(c0 + 6655, 10'd0,   10'd0,   10'd0,   "white_s27");
    expect_mix(c0 + 6656, 10'd255, 10'd255, 10'd255, "white_s28");
    expect_mix(c0 + 7168, 10'd0,   10'd0,   10'd0,   "white_s29");
    expect_mix(c0 + 8191, 10'd0,   10'd0,   10'd0,   "white_s30");
    expect_mix(c0 + 8192, 10'd255, 10'd255, 10'd255, "white_s31");
    expect_mix(c0 + 8704, 10'd0,   10'd0,   10'd0,   "white_s32");
    wait_cyc(c0 + 8710);

    // Periodic noise after reseed: a single one circulating, period 16 shifts.
    strobe(8'hE0, 1'b0, ep);
    repeat (34) @(negedge clk);
    wait_val(10'd255, 1'b1, 16 * 512 + 600, "periodic_first_one", c1);
    check("periodic_first_one_time", 10'((c1 - ep > 14 * 512) && (c1 - ep <= 15 * 512 + 20)), 10'd1);
    expect_mix(c1 + 511,  10'd255, 10'd255, 10'd255, "periodic_s15");
    expect_mix(c1 + 512,  10'd0,   10'd0,   10'd0,   "periodic_s16");
    expect_mix(c1 + 8191, 10'd0,   10'd0,   10'd0,   "periodic_s30");
    expect_mix(c1 + 8192, 10'd255, 10'd255, 10'd255, "periodic_s31");
    expect_mix(c1 + 8704, 10'd0,   10'd0,   10'd0,   "periodic_s32");
    wait_cyc(c1 + 8710);

    // Tone1 period 1 (DC high), vol 2, panned left only.
    wr(8'hFF, 1'b0); wr(8'hA1, 1'b0); wr(8'h00, 1'b0); wr(8'hB2, 1'b0);
    strobe(8'h20, 1'b1, es);
    expect_mix(es + 5,   10'd161, 10'd0, 10'd161, "pan_left");
    expect_mix(es + 200, 10'd161, 10'd0, 10'd161, "pan_left_hold");
    wait_cyc(es + 205);

    // All channels full volume, tones DC high, noise pulse high: 1020, no wrap.
    wr(8'h81, 1'b0); wr(8'h00, 1'b0); wr(8'hC1, 1'b0); wr(8'h00, 1'b0);
    wr(8'hFF, 1'b1);
    wr(8'h90, 1'b0); wr(8'hB0, 1'b0); wr(8'hD0, 1'b0); wr(8'hF0, 1'b0);
    wait_val(10'd765, 1'b1, 9000, "max_tones_only", c);
    wait_val(10'd765, 1'b0, 9000, "max_noise_on", c2);
    expect_mix(c2 + 1,   10'd1020, 10'd1020, 10'd1020, "max_mix");
    expect_mix(c2 + 300, 10'd1020, 10'd1020, 10'd1020, "max_mix_hold");
    expect_mix(c2 + 600, 10'd765,  10'd765,  10'd765,  "max_noise_off");
    wait_cyc(c2 + 605);

    for (int unsigned k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
